// File: rtl/mem_stage_if.sv
// Byte-serial shared memory port: the MEM stage is the master, the arbiter/memory is the slave.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] a;
    logic              wr;
    logic [7:0]        dout;
    logic [7:0]        din;
    logic              gnt;

    modport master (output a, wr, dout, input din, gnt);
    modport slave  (input a, wr, dout, output din, gnt);
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the five-stage RISC-V core: byte-serial LB/LH/LW/LBU/LHU/SB/SH/SW over mem_bus.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_enable_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_enable_o,
    output logic              stall_req_o,
    mem_stage_if.master       mem_bus,
    output logic              misalign_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, ACC, TAIL, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d, next_cnt;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;
    logic              pend_q, pend_d;
    logic [1:0]        lane_q, lane_d;

    logic              is_load, is_store, is_mem, is_signed;
    logic [1:0]        last_idx;
    logic [DATA_W-1:0] load_val;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic misaligned;
    assign misaligned = (last_idx == 2'd1 && mem_addr_i[0]) ||
                        (last_idx == 2'd3 && mem_addr_i[1:0] != 2'b00);
`endif

    // last_idx is the index of the final byte (N-1); codes 9-15 decode as NONE.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        last_idx  = 2'd0;
        case (mem_op_i)
            OP_LB:  begin is_load  = 1'b1; is_signed = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_signed = 1'b1; last_idx = 2'd1; end
            OP_LW:  begin is_load  = 1'b1; last_idx = 2'd3; end
            OP_LBU: is_load = 1'b1;
            OP_LHU: begin is_load  = 1'b1; last_idx = 2'd1; end
            OP_SB:  is_store = 1'b1;
            OP_SH:  begin is_store = 1'b1; last_idx = 2'd1; end
            OP_SW:  begin is_store = 1'b1; last_idx = 2'd3; end
            default: ;
        endcase
    end
    assign is_mem = is_load | is_store;

    always_comb begin
        // NOTE: every next-value gets a default first, so no path through this block infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        a_d      = a_q;
        wr_d     = wr_q;
        dout_d   = dout_q;
        pend_d   = 1'b0;
        lane_d   = lane_q;
        next_cnt = cnt_q + 2'd1;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        // Read data arrives the cycle after its grant; drop it into the lane it was issued for.
        if (pend_q) asm_d[{lane_q, 3'b000} +: 8] = mem_bus.din;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_d = misaligned;
                    if (misaligned) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACC;
                        cnt_d   = 2'd0;
                        a_d     = mem_addr_i;
                        wr_d    = is_store;
                        dout_d  = store_data_i[7:0];
                        asm_d   = '0;
                    end
`else
                    state_d = ACC;
                    cnt_d   = 2'd0;
                    a_d     = mem_addr_i;
                    wr_d    = is_store;
                    dout_d  = store_data_i[7:0];
                    asm_d   = '0;
`endif
                end
            end
            ACC: begin
                if (mem_bus.gnt) begin
                    if (!wr_q) begin
                        pend_d = 1'b1;
                        lane_d = cnt_q;
                    end
                    if (cnt_q == last_idx) begin
                        state_d = wr_q ? DONE : TAIL;
                        wr_d    = 1'b0;
                    end else begin
                        cnt_d  = next_cnt;
                        a_d    = mem_addr_i + ADDR_W'(next_cnt);
                        dout_d = store_data_i[{next_cnt, 3'b000} +: 8];
                    end
                end
            end
            TAIL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: every register is small control/data state, so all of them take the synchronous reset.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            a_q     <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            pend_q  <= 1'b0;
            lane_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            a_q     <= a_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    always_comb begin
        case (last_idx)
            2'd0:    load_val = {{24{is_signed & asm_q[7]}},  asm_q[7:0]};
            2'd1:    load_val = {{16{is_signed & asm_q[15]}}, asm_q[15:0]};
            default: load_val = asm_q;
        endcase
    end

    always_comb begin
        rd_addr_o   = rd_addr_i;
        rd_data_o   = rd_data_i;
        rd_enable_o = 1'b0;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem) stall_req_o = 1'b1;
                else        rd_enable_o = rd_enable_i;
            end
            ACC, TAIL: stall_req_o = 1'b1;
            DONE: begin
                if (is_load) begin
                    rd_enable_o = rd_enable_i;
                    rd_data_o   = load_val;
                end
            end
            default: ;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        if (state_q == DONE && mis_q) begin
            rd_enable_o = 1'b0;
            rd_data_o   = rd_data_i;
            misalign_o  = 1'b1;
        end
`endif
        if (rst) begin
            rd_enable_o = 1'b0;
            stall_req_o = 1'b0;
        end
    end

    assign mem_bus.a    = a_q;
    assign mem_bus.wr   = wr_q;
    assign mem_bus.dout = dout_q;
endmodule
